// File: rtl/hdmi_tx_init_seq_if.sv
// Byte-write request channel between the HDMI init sequencer and the I2C master.
interface hdmi_tx_init_seq_if;
  logic       i2c_req;
  logic [7:0] i2c_addr;
  logic [7:0] i2c_wdata;
  logic       i2c_done;
  logic       i2c_nack;

  modport master (output i2c_req, i2c_addr, i2c_wdata, input i2c_done, i2c_nack);
  modport slave  (input i2c_req, i2c_addr, i2c_wdata, output i2c_done, i2c_nack);
endinterface

// File: rtl/hdmi_tx_init_seq.sv
// HDMI transmitter power-up/hot-plug sequencer: reset pulse, settle wait, then one
// I2C write per register-table entry with NACK retries; re-runs on hot-plug interrupt.
module hdmi_tx_init_seq #(
  parameter int RST_CYCLES  = 1000,
  parameter int WAIT_CYCLES = 10000,
  parameter int NUM_REGS    = 32,
  parameter int RETRY_MAX   = 3,
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk_50m,
  input  logic                      reset,
  input  logic                      reinit_req,
  input  logic                      hdmi_int_n,
  output logic                      hdmi_tx_rst_n,
  output logic [IW-1:0]             tbl_idx,
  input  logic [15:0]               tbl_data,
  hdmi_tx_init_seq_if.master        i2c,
  output logic                      busy,
  output logic                      tx_ready,
  output logic                      cfg_err,
  output logic [IW-1:0]             err_idx,
  output logic [7:0]                nack_cnt
);

  localparam int CMAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RTW  = $clog2(RETRY_MAX + 2);
  localparam logic [RTW-1:0] RMAX = RTW'(RETRY_MAX);

  typedef enum logic [3:0] {
    S_RST_ASSERT, S_RST_WAIT, S_FETCH, S_LOAD, S_WRITE, S_GAP, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [RTW-1:0]  r_retry;
  logic [7:0]      r_addr, r_wdata, r_nack;
  logic [IW-1:0]   r_err_idx;
  logic            r_int_pend;
  logic [2:0]      r_int_sync;
  logic            w_int_evt;

  // Two resync flops plus one history flop; event fires on the synchronised falling edge.
  always_ff @(posedge clk_50m) begin
    if (reset) r_int_sync <= '1;
    else       r_int_sync <= {r_int_sync[1:0], hdmi_int_n};
  end
  assign w_int_evt = r_int_sync[2] & ~r_int_sync[1];

  always_ff @(posedge clk_50m) begin
    if (reset) r_state <= S_RST_ASSERT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST_ASSERT: if (r_cnt == CW'(RST_CYCLES - 1))  w_next = S_RST_WAIT;
      S_RST_WAIT:   if (r_cnt == CW'(WAIT_CYCLES - 1)) w_next = S_FETCH;
      S_FETCH:      w_next = S_LOAD;
      S_LOAD:       w_next = (tbl_data[15:8] == 8'hFF) ? S_DONE : S_WRITE;
      S_WRITE: begin
        if (i2c.i2c_done) begin
          if (!i2c.i2c_nack)     w_next = S_NEXT;
          else if (r_retry < RMAX) w_next = S_GAP;
          else                   w_next = S_ERROR;
        end
      end
      S_GAP:        w_next = S_WRITE;
      S_NEXT:       w_next = (r_idx == IW'(NUM_REGS - 1)) ? S_DONE : S_FETCH;
      S_DONE:       if (w_int_evt || r_int_pend) w_next = S_FETCH;
      S_ERROR:      w_next = S_ERROR;
      default:      w_next = S_RST_ASSERT;
    endcase
    if (reinit_req) w_next = S_RST_ASSERT;
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_nack     <= '0;
      r_err_idx  <= '0;
      r_int_pend <= 1'b0;
    end else begin
      // Counter restarts on every state change and on reinit, even when already in RST_ASSERT.
      if (reinit_req || w_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_RST_ASSERT || r_state == S_RST_WAIT)
        r_cnt <= r_cnt + 1'b1;

      if (reinit_req)
        r_idx <= '0;
      else if (w_next == S_FETCH)
        r_idx <= (r_state == S_NEXT) ? r_idx + 1'b1 : '0;

      if (r_state == S_LOAD) begin
        r_retry <= '0;
        r_addr  <= tbl_data[15:8];
        r_wdata <= tbl_data[7:0];
      end else if (r_state == S_WRITE && w_next == S_GAP) begin
        r_retry <= r_retry + 1'b1;
      end

      if (r_state == S_WRITE && i2c.i2c_done && i2c.i2c_nack && r_nack != 8'hFF)
        r_nack <= r_nack + 1'b1;

      if (w_next == S_ERROR && r_state != S_ERROR)
        r_err_idx <= r_idx;

      // DONE consumes a pending request as it restarts the table.
      if (reinit_req || r_state == S_DONE)
        r_int_pend <= 1'b0;
      else if (w_int_evt && r_state != S_ERROR)
        r_int_pend <= 1'b1;
    end
  end

  always_comb begin
    hdmi_tx_rst_n = (r_state != S_RST_ASSERT);
    i2c.i2c_req   = (r_state == S_WRITE);
    busy          = (r_state != S_DONE) && (r_state != S_ERROR);
    tx_ready      = (r_state == S_DONE);
    cfg_err       = (r_state == S_ERROR);
  end

  assign i2c.i2c_addr  = r_addr;
  assign i2c.i2c_wdata = r_wdata;
  assign tbl_idx       = r_idx;
  assign err_idx       = r_err_idx;
  assign nack_cnt      = r_nack;

endmodule

// File: tb/tb_hdmi_tx_init_seq.sv
// Directed bench for hdmi_tx_init_seq: write-list/timing model, I2C slave and table RAM models.
module tb_hdmi_tx_init_seq;
  localparam int RC = 4, WC = 8, NR = 4, RM = 3, LAT = 5;

  logic        clk_50m = 1'b0;
  logic        reset, reinit_req, hdmi_int_n;
  logic        hdmi_tx_rst_n, busy, tx_ready, cfg_err;
  logic [1:0]  tbl_idx, err_idx;
  logic [15:0] tbl_data;
  logic [7:0]  nack_cnt;

  hdmi_tx_init_seq_if bus();

  hdmi_tx_init_seq #(.RST_CYCLES(RC), .WAIT_CYCLES(WC), .NUM_REGS(NR), .RETRY_MAX(RM)) dut (
    .clk_50m(clk_50m), .reset(reset), .reinit_req(reinit_req), .hdmi_int_n(hdmi_int_n),
    .hdmi_tx_rst_n(hdmi_tx_rst_n), .tbl_idx(tbl_idx), .tbl_data(tbl_data), .i2c(bus),
    .busy(busy), .tx_ready(tx_ready), .cfg_err(cfg_err), .err_idx(err_idx), .nack_cnt(nack_cnt)
  );

  always #5 clk_50m = ~clk_50m;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk_50m) cyc++;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Register table RAM, one-cycle read latency.
  logic [15:0] tbl [NR];
  always @(posedge clk_50m) tbl_data <= tbl[tbl_idx];

  // I2C master model: done LAT cycles after req; entry i NACKs its first nplan[i] attempts.
  int   nplan [NR];
  int   att [NR];
  int   s_cnt = 0;
  logic s_done = 1'b0, s_nack = 1'b0, inj_done = 1'b0, inj_nack = 1'b0;
  always @(negedge clk_50m) begin
    s_done = 1'b0;
    s_nack = 1'b0;
    if (bus.i2c_req) begin
      s_cnt++;
      if (s_cnt == LAT) begin
        s_done = 1'b1;
        s_nack = (att[tbl_idx] < nplan[tbl_idx]);
        att[tbl_idx]++;
        s_cnt = 0;
      end
    end else begin
      s_cnt = 0;
    end
  end
  assign bus.i2c_done = s_done | inj_done;
  assign bus.i2c_nack = s_nack | inj_nack;

  // Model: expected attempts {retry, addr, data}, cycles from first FETCH to DONE/ERROR.
  logic [16:0] expq [$];
  int exp_nack = 0, exp_time = 0, exp_err_idx = 0;
  bit exp_err = 1'b0;

  function automatic void model_pass();
    int t;
    t = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      int n;
      int a;
      if (tbl[i][15:8] == 8'hFF) begin
        t += 2;
        break;
      end
      n = (nplan[i] > RM + 1) ? RM + 1 : nplan[i];
      a = (n == RM + 1) ? RM + 1 : n + 1;
      for (int k = 0; k < a; k++) expq.push_back({(k != 0) ? 1'b1 : 1'b0, tbl[i]});
      exp_nack = (exp_nack + n > 255) ? 255 : exp_nack + n;
      t += 2 + a * LAT + (a - 1);
      if (n == RM + 1) begin
        exp_err = 1'b1;
        exp_err_idx = int'(i);
        break;
      end
      t += 1;
    end
    exp_time = t;
  endfunction

  function automatic void new_model();
    expq.delete();
    exp_err = 1'b0;
    exp_err_idx = 0;
    for (int unsigned i = 0; i < NR; i++) att[i] = 0;
    model_pass();
  endfunction

  // Single compare/monitor process.
  bit   mon_en = 1'b0;
  logic prev_rst = 1'b0, prev_req = 1'b0, prev_rdy = 1'b0;
  int   low_run, low_total, last_low_len, rel_cyc, first_req_cyc, req_rises;
  int   ready_rises, ready_cyc, ready_fall_cyc, fall_cyc, max_idx;
  logic [16:0] mon_e;
  logic [15:0] cur_aw;

  always @(negedge clk_50m) begin
    if (mon_en) begin
      chk("busy_flags", busy, !(tx_ready || cfg_err));
      if (!hdmi_tx_rst_n) begin
        low_run++;
        low_total++;
      end else if (!prev_rst) begin
        last_low_len = low_run;
        low_run = 0;
        rel_cyc = cyc;
      end
      if (bus.i2c_req && !prev_req) begin
        req_rises++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        chk("exp_pending", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          mon_e = expq.pop_front();
          chk("wr_addr", bus.i2c_addr, mon_e[15:8]);
          chk("wr_data", bus.i2c_wdata, mon_e[7:0]);
          if (mon_e[16]) chk("retry_gap", cyc - fall_cyc, 1);
        end
        cur_aw = {bus.i2c_addr, bus.i2c_wdata};
      end else if (bus.i2c_req) begin
        chk("wr_stable", {bus.i2c_addr, bus.i2c_wdata}, cur_aw);
      end
      if (!bus.i2c_req && prev_req) fall_cyc = cyc;
      if (tx_ready && !prev_rdy) begin
        ready_rises++;
        ready_cyc = cyc;
      end
      if (!tx_ready && prev_rdy) ready_fall_cyc = cyc;
      if (int'(tbl_idx) > max_idx) max_idx = int'(tbl_idx);
    end
    prev_rst = hdmi_tx_rst_n;
    prev_req = bus.i2c_req;
    prev_rdy = tx_ready;
  end

  task automatic clear_mon();
    low_run = 0; low_total = 0; last_low_len = -1; rel_cyc = -1; first_req_cyc = -1;
    req_rises = 0; ready_rises = 0; ready_cyc = -1; ready_fall_cyc = -1; fall_cyc = -1; max_idx = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_50m);
      #1;
    end
  endtask

  task automatic do_reset();
    step(1);
    reset = 1'b1;
    step(1);
    mon_en = 1'b1;
    chk("rst_hdmi_rst_n", hdmi_tx_rst_n, 0);
    chk("rst_i2c_req", bus.i2c_req, 0);
    chk("rst_i2c_addr", bus.i2c_addr, 0);
    chk("rst_i2c_wdata", bus.i2c_wdata, 0);
    chk("rst_tbl_idx", tbl_idx, 0);
    chk("rst_busy", busy, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_err_idx", err_idx, 0);
    chk("rst_nack_cnt", nack_cnt, 0);
    clear_mon();
    exp_nack = 0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic pulse_reinit();
    step(1);
    clear_mon();
    reinit_req = 1'b1;
    step(1);
    reinit_req = 1'b0;
  endtask

  task automatic pulse_int(input bit chk_lat);
    step(1);
    hdmi_int_n = 1'b0;
    step(2);
    if (chk_lat) chk("int_lat_before", tx_ready, 1);
    step(1);
    if (chk_lat) chk("int_lat_after", tx_ready, 0);
    hdmi_int_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy && k < budget) begin step(1); k++; end
    chk(nm, busy, 0);
  endtask

  task automatic wait_rises(input string nm, input int n, input int budget);
    int k = 0;
    while (ready_rises < n && k < budget) begin step(1); k++; end
    chk(nm, ready_rises >= n, 1);
  endtask

  task automatic wait_req(input string nm, input int n, input int budget);
    int k = 0;
    while (req_rises < n && k < budget) begin step(1); k++; end
    chk(nm, req_rises >= n, 1);
  endtask

  task automatic final_checks();
    chk("fin_tx_ready", tx_ready, !exp_err);
    chk("fin_cfg_err", cfg_err, exp_err);
    if (exp_err) chk("fin_err_idx", err_idx, exp_err_idx);
    chk("fin_nack_cnt", nack_cnt, exp_nack);
    chk("fin_queue_empty", expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reinit_req = 1'b0; hdmi_int_n = 1'b1;
    for (int unsigned i = 0; i < NR; i++) nplan[i] = 0;

    // 1: three entries then end marker, all ACK
    tbl = '{16'hA111, 16'hA222, 16'hA333, 16'hFF00};
    do_reset();
    new_model();
    wait_idle("t1_idle", 300);
    chk("t1_rst_low_len", last_low_len, 4);
    chk("t1_first_req", first_req_cyc - rel_cyc, 10);
    chk("t1_ready_lit", ready_cyc - rel_cyc, 34);
    chk("t1_ready_model", ready_cyc - rel_cyc, WC + exp_time);
    chk("t1_writes", req_rises, 3);
    chk("t1_max_idx", max_idx, 3);
    final_checks();

    // 2: full table, no marker
    tbl = '{16'hB001, 16'hB102, 16'hB203, 16'hB304};
    pulse_reinit();
    new_model();
    wait_idle("t2_idle", 300);
    chk("t2_writes", req_rises, 4);
    chk("t2_ready_lit", ready_cyc - rel_cyc, 40);
    chk("t2_ready_model", ready_cyc - rel_cyc, WC + exp_time);
    chk("t2_tbl_idx", tbl_idx, 3);
    chk("t2_max_idx", max_idx, 3);
    final_checks();

    // 3: entry 1 NACKs twice
    nplan[1] = 2;
    do_reset();
    new_model();
    wait_idle("t3_idle", 400);
    chk("t3_writes", req_rises, 6);
    chk("t3_nack_lit", nack_cnt, 2);
    chk("t3_ready_lit", ready_cyc - rel_cyc, 52);
    chk("t3_ready_model", ready_cyc - rel_cyc, WC + exp_time);
    final_checks();

    // 4: entry 2 always NACKs -> error, interrupt ignored, reinit recovers
    nplan[1] = 0; nplan[2] = 99;
    do_reset();
    new_model();
    wait_idle("t4_idle", 400);
    chk("t4_cfg_err", cfg_err, 1);
    chk("t4_err_idx", err_idx, 2);
    chk("t4_tx_ready", tx_ready, 0);
    chk("t4_nack_lit", nack_cnt, 4);
    chk("t4_writes", req_rises, 6);
    final_checks();
    pulse_int(1'b0);
    step(8);
    chk("t4_int_ign_err", cfg_err, 1);
    chk("t4_int_ign_busy", busy, 0);
    chk("t4_int_ign_req", req_rises, 6);
    nplan[2] = 0;
    pulse_reinit();
    chk("t4_reinit_cfg_err", cfg_err, 0);
    chk("t4_reinit_rst_n", hdmi_tx_rst_n, 0);
    new_model();
    wait_idle("t4b_idle", 300);
    chk("t4b_rst_low_len", last_low_len, 4);
    final_checks();

    // 5a: hot-plug interrupt in DONE rewrites table without transmitter reset
    tbl = '{16'hA111, 16'hA222, 16'hA333, 16'hFF00};
    clear_mon();
    new_model();
    pulse_int(1'b1);
    wait_rises("t5_done", 1, 300);
    chk("t5_no_rst", low_total, 0);
    chk("t5_writes", req_rises, 3);
    chk("t5_ready_lit", ready_cyc - ready_fall_cyc, 26);
    chk("t5_ready_model", ready_cyc - ready_fall_cyc, exp_time);
    final_checks();

    // 5b: interrupt mid-write finishes the pass, then restarts exactly once
    clear_mon();
    new_model();
    pulse_int(1'b0);
    wait_req("t5b_req", 2, 100);
    pulse_int(1'b0);
    model_pass();
    wait_rises("t5b_done", 2, 400);
    step(20);
    chk("t5b_ready_rises", ready_rises, 2);
    chk("t5b_writes", req_rises, 6);
    chk("t5b_no_rst", low_total, 0);
    chk("t5b_ready_model", ready_cyc - ready_fall_cyc, exp_time);
    final_checks();

    // 6: reinit mid-write, stale done+nack ignored during reset wait
    clear_mon();
    new_model();
    pulse_int(1'b0);
    wait_req("t6_req", 1, 100);
    step(2);
    pulse_reinit();
    chk("t6_req_drop", bus.i2c_req, 0);
    chk("t6_rst_n_low", hdmi_tx_rst_n, 0);
    new_model();
    begin
      int k = 0;
      while (!hdmi_tx_rst_n && k < 50) begin step(1); k++; end
      chk("t6_released", hdmi_tx_rst_n, 1);
    end
    step(1);
    inj_done = 1'b1; inj_nack = 1'b1;
    step(1);
    inj_done = 1'b0; inj_nack = 1'b0;
    wait_idle("t6_idle", 300);
    chk("t6_rst_low_len", last_low_len, 4);
    chk("t6_ready_model", ready_cyc - rel_cyc, WC + exp_time);
    chk("t6_writes", req_rises, 3);
    final_checks();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hdmi_tx_init_seq.md
Name: hdmi_tx_init_seq

Overview:
- Power-up and hot-plug configuration sequencer for the HDMI transmitter.
- Pulses the transmitter reset, waits for it to settle, then walks a register table and issues one I2C write per entry to an external byte-write I2C master.
- Flags the link as configured; re-runs the table on a hot-plug interrupt.
- Sits between the soft-CPU control plane and the I2C master, alongside the video pattern generator, which it gates via tx_ready.

Parameters:
RST_CYCLES, 1000, cycles hdmi_tx_rst_n is held low (>=1)
WAIT_CYCLES, 10000, cycles after reset release before first write (>=1)
NUM_REGS, 32, table depth; index width IW = clog2(NUM_REGS)
RETRY_MAX, 3, extra attempts per entry after a NACK (0 = no retry)

Ports:
clk_50m  in  1  clock
reset  in  1  synchronous active-high reset
reinit_req  in  1  pulse: full re-init (reset pulse + table)
hdmi_int_n  in  1  async transmitter interrupt, active low
hdmi_tx_rst_n  out  1  transmitter reset, active low
tbl_idx  out  IW  table read index
tbl_data  in  16  table entry, [15:8] reg addr, [7:0] value; 1-cycle read latency
i2c_req  out  1  write request to I2C master
i2c_addr  out  8  register address
i2c_wdata  out  8  register value
i2c_done  in  1  1-cycle pulse, transaction finished
i2c_nack  in  1  qualifies i2c_done: transaction NACKed
busy  out  1  sequence in progress
tx_ready  out  1  table completed without error
cfg_err  out  1  entry failed after RETRY_MAX retries
err_idx  out  IW  index of failing entry
nack_cnt  out  8  total NACKs since reset, saturating at 255

Behaviour:
- Reset values:
  - state=RST_ASSERT, counter=0.
  - hdmi_tx_rst_n=0, i2c_req=0, i2c_addr=0, i2c_wdata=0, tbl_idx=0.
  - busy=1, tx_ready=0, cfg_err=0, err_idx=0, nack_cnt=0.
- hdmi_int_n is resynchronised with 2 flops. A falling edge on the synchronised signal produces int_evt (1 cycle); total latency from the pin is 3 cycles.
- States:
  - RST_ASSERT:
    - hdmi_tx_rst_n=0 for exactly RST_CYCLES cycles.
    - Then go to RST_WAIT, clear the counter, drive hdmi_tx_rst_n=1.
  - RST_WAIT: count WAIT_CYCLES, then go to FETCH with tbl_idx=0.
  - FETCH: present tbl_idx; go to LOAD next cycle.
  - LOAD:
    - Capture tbl_data into i2c_addr/i2c_wdata and clear the retry count.
    - If tbl_data[15:8]==8'hFF (end marker), go to DONE. Otherwise go to WRITE.
  - WRITE:
    - i2c_req=1 and stays high, with addr/data stable, until i2c_done.
    - i2c_done with i2c_nack=0: i2c_req=0 in the same edge, go to NEXT.
    - i2c_done with i2c_nack=1:
      - nack_cnt += 1 (saturating).
      - If retries < RETRY_MAX: retries += 1, drop i2c_req for one cycle (GAP), re-enter WRITE.
      - Else: go to ERROR.
  - NEXT:
    - If tbl_idx==NUM_REGS-1, go to DONE. No wrap; the end marker is optional.
    - Else tbl_idx += 1, go to FETCH.
  - DONE: tx_ready=1, busy=0.
  - ERROR: cfg_err=1, err_idx=tbl_idx, busy=0, tx_ready=0.
- Per-entry cost: 2 cycles fetch/load + I2C time + 1 cycle NEXT.
- Event priority, highest first: reset > reinit_req > int_evt.
  - reinit_req in any state:
    - Next cycle: RST_ASSERT, tx_ready=0, cfg_err=0.
    - An in-flight i2c_req drops immediately. The I2C master must tolerate request withdrawal and any later i2c_done is ignored.
  - int_evt:
    - In DONE: go to FETCH with tbl_idx=0, tx_ready=0, no transmitter reset.
    - In ERROR: ignored.
    - In any other state: latched into int_pend; restarts the table once DONE is reached. int_pend is cleared by reinit_req.
- busy = state not in {DONE, ERROR}.
- i2c_done is ignored outside WRITE.
- nack_cnt is cleared only by reset.

Test Plan:
1. Reset, then RST_CYCLES=4, WAIT_CYCLES=8, table of 3 entries then 16'hFF00, I2C model done 5 cycles after req, all ACK
   -> hdmi_tx_rst_n low exactly 4 cycles; first i2c_req 8+2 cycles after release; writes (addr,data) in table order; tx_ready=1 after 3rd done + NEXT + 2; tbl_idx never reaches 4.
2. Full table NUM_REGS=4, no end marker
   -> exactly 4 writes; tx_ready=1; tbl_idx stops at 3 with no wrap.
3. Entry 1 NACKs twice then ACKs, RETRY_MAX=3
   -> 3 requests for entry 1, each separated by 1 low cycle; nack_cnt=2; tx_ready=1; cfg_err=0.
4. Entry 2 always NACKs, RETRY_MAX=3
   -> 4 attempts; cfg_err=1; err_idx=2; busy=0; nack_cnt=4. A following hdmi_int_n fall does nothing; reinit_req restarts from RST_ASSERT and clears cfg_err.
5. In DONE, pulse hdmi_int_n low
   -> 3 cycles later tx_ready=0 and the table rewrites from idx 0; hdmi_tx_rst_n stays 1. The same pulse during a WRITE lets that sequence finish, then it restarts once.
6. reinit_req asserted mid-WRITE while i2c_req=1
   -> i2c_req=0 next cycle; hdmi_tx_rst_n=0 for RST_CYCLES; a stale i2c_done arriving later is ignored.
